// File: rtl/fifo_read_drain_if.sv
// Signal bundle between the FIFO read side, the drain block and the downstream consumer.
// The slave modport is the drain block's view; the master modport is the environment's view.
interface fifo_read_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  r_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  chk_en;
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic                  seq_err;

  modport slave (
    input  empty, data_out, m_ready, chk_en,
    output r_en, m_valid, m_data, rd_cnt, err_cnt, seq_err
  );

  modport master (
    output empty, data_out, m_ready, chk_en,
    input  r_en, m_valid, m_data, rd_cnt, err_cnt, seq_err
  );
endinterface

// File: rtl/fifo_read_drain.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer,
// counting delivered words and checking that they form an incrementing sequence.
module fifo_read_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  fifo_read_drain_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } chk_state_e;

  chk_state_e            state_q, state_d;
  logic [1:0]            count_q, count_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                  seq_err_q, seq_err_d;
  logic                  pop_s;
  logic                  r_en_s;
  logic [2:0]            occ_s;

  assign pop_s = (count_q != 2'd0) && bus.m_ready;

  // Slots committed after this cycle's pop; a read is issued only if one will still be free.
  always_comb begin
    occ_s  = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop_s};
    r_en_s = !rrst && !bus.empty && (occ_s < 3'd2);
  end

  // Skid buffer: buf0 is always the oldest word and feeds m_data directly.
  always_comb begin
    count_d   = count_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    pending_d = r_en_s;
    rd_cnt_d  = rd_cnt_q + CNT_WIDTH'(pop_s);
    case ({pending_q, pop_s})
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          buf0_d = bus.data_out;
        end else begin
          buf1_d = bus.data_out;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = bus.data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.data_out;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Checker state register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Checker next state; dropping chk_en always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (!bus.chk_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    state_d = pop_s ? CHECK : SYNC;
        CHECK:   state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Checker outputs; a mismatch resynchronises on the observed word.
  always_comb begin
    exp_d     = exp_q;
    err_cnt_d = err_cnt_q;
    seq_err_d = seq_err_q;
    case (state_q)
      SYNC: begin
        if (pop_s) begin
          exp_d = buf0_q + DATA_WIDTH'(1);
        end else begin
          exp_d = exp_q;
        end
      end
      CHECK: begin
        if (pop_s) begin
          if (buf0_q != exp_q) begin
            seq_err_d = 1'b1;
            if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
              err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else begin
            seq_err_d = seq_err_q;
          end
          exp_d = buf0_q + DATA_WIDTH'(1);
        end else begin
          exp_d = exp_q;
        end
      end
      default: begin
        exp_d = exp_q;
      end
    endcase
  end

  // Datapath and counter registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      count_q   <= 2'd0;
      pending_q <= 1'b0;
      buf0_q    <= {DATA_WIDTH{1'b0}};
      buf1_q    <= {DATA_WIDTH{1'b0}};
      exp_q     <= {DATA_WIDTH{1'b0}};
      rd_cnt_q  <= {CNT_WIDTH{1'b0}};
      err_cnt_q <= {CNT_WIDTH{1'b0}};
      seq_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      exp_q     <= exp_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign bus.r_en    = r_en_s;
  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign bus.rd_cnt  = rd_cnt_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.seq_err = seq_err_q;

endmodule
